// File: rtl/seq_lane_sched_pkg.sv
// seq_det_pkg: shared defaults and helper functions for the lane-multiplexed sequence detector
package seq_det_pkg;
  localparam int DEF_PAT_LEN = 4;
  localparam logic [7:0] DEF_PAT = 8'b0000_1011;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? max : v + 32'd1;
  endfunction
endpackage

// File: rtl/seq_lane_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting the search at ptr
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter int LANES = 4,
  parameter int IW = id_w(LANES)
) (
  input  logic [LANES-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             en,
  output logic [LANES-1:0] gnt,
  output logic [IW-1:0]    gnt_id
);
  logic found;
  int idx;
  // first requester at or above ptr, wrapping, wins the single grant
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < LANES; k++) begin
      idx = (int'(ptr) + k) % LANES;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id = IW'(idx);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/seq_lane_sched.sv
// seq_lane_sched: one pattern-match engine time-shared across serial lanes with lane-tagged events
module seq_lane_sched
  import seq_det_pkg::*;
#(
  parameter int LANES = 4,
  parameter int PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PAT = DEF_PAT[PAT_LEN-1:0],
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [LANES-1:0]         bit_valid,
  input  logic [LANES-1:0]         bit_data,
  output logic [LANES-1:0]         bit_ready,
  output logic                     evt_valid,
  output logic [$clog2(LANES)-1:0] evt_lane,
  input  logic                     evt_ready,
  input  logic [$clog2(LANES)-1:0] cnt_sel,
  output logic [CNT_W-1:0]         cnt_val
);
  localparam int IW = id_w(LANES);
  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
  logic [PAT_LEN-1:0] hist [LANES];
  logic [FW-1:0]      fill [LANES];
  logic [CNT_W-1:0]   cnt  [LANES];
  logic [IW-1:0]      rr_ptr, gnt_id;
  logic               stall, take, match;
  logic [PAT_LEN-1:0] hist_nxt;
  logic [FW-1:0]      fill_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  assign stall = evt_valid & ~evt_ready;
  assign cnt_val = (int'(cnt_sel) < LANES) ? cnt[cnt_sel] : '0;
  rr_arbiter #(.LANES(LANES), .IW(IW)) u_arb (
    .req(bit_valid),
    .ptr(rr_ptr),
    .en(~stall & ~clear),
    .gnt(bit_ready),
    .gnt_id(gnt_id)
  );
  // shared compare on the granted lane's post-shift history
  always_comb begin
    take = |bit_ready;
    hist_nxt = {hist[gnt_id][PAT_LEN-2:0], bit_data[gnt_id]};
    fill_nxt = FW'(sat_inc(32'(fill[gnt_id]), 32'(PAT_LEN)));
    cnt_nxt = CNT_W'(sat_inc(32'(cnt[gnt_id]), CNT_MAX));
    match = take && hist_nxt == PAT && fill_nxt == FW'(PAT_LEN);
  end
  // per-lane history, fill and match counters; only the granted lane moves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (clear) begin
      for (int i = 0; i < LANES; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      if (take) begin
        hist[gnt_id] <= hist_nxt;
        fill[gnt_id] <= fill_nxt;
      end
      if (match) cnt[gnt_id] <= cnt_nxt;
    end
  end
  // round-robin pointer and event slot; a fresh match overrides a same-cycle handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      evt_valid <= 1'b0;
      evt_lane <= '0;
    end else if (clear) begin
      rr_ptr <= '0;
      evt_valid <= 1'b0;
      evt_lane <= '0;
    end else begin
      if (take) rr_ptr <= (gnt_id == IW'(LANES - 1)) ? '0 : gnt_id + 1'b1;
      if (match) begin
        evt_valid <= 1'b1;
        evt_lane <= gnt_id;
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_lane_sched.sv
// tb_seq_lane_sched: directed scenarios plus random traffic checked against a behavioural model
module tb_seq_lane_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] bit_valid = '0;
  logic [3:0] bit_data = '0;
  logic [3:0] bit_ready;
  logic       evt_valid;
  logic [1:0] evt_lane;
  logic       evt_ready = 1'b0;
  logic [1:0] cnt_sel = '0;
  logic [7:0] cnt_val;
  int n_cmp = 0;
  int n_bad = 0;
  int hist_m [4];
  int fill_m [4];
  int cnt_m [4];
  bit ev_v;
  int ev_l;
  int ptr_m;

  seq_lane_sched dut (
    .clk(clk), .rst(rst), .clear(clear),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
    .evt_valid(evt_valid), .evt_lane(evt_lane), .evt_ready(evt_ready),
    .cnt_sel(cnt_sel), .cnt_val(cnt_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      hist_m[i] = 0;
      fill_m[i] = 0;
      cnt_m[i] = 0;
    end
    ev_v = 0;
    ev_l = 0;
    ptr_m = 0;
  endfunction

  // one clock: drive at negedge, check outputs against the model, advance the model, reach next negedge
  task automatic cyc(input logic [3:0] v, input logic [3:0] d, input logic er, input logic cl, input int sel);
    int g;
    int idx;
    bit hit;
    logic [3:0] exp_rdy;
    bit_valid = v;
    bit_data = d;
    evt_ready = er;
    clear = cl;
    cnt_sel = sel[1:0];
    #1;
    g = -1;
    if (!cl && !(ev_v && !er))
      for (int k = 0; k < 4; k++) begin
        idx = (ptr_m + k) % 4;
        if (g < 0 && v[idx]) g = idx;
      end
    exp_rdy = (g < 0) ? 4'b0 : 4'(1 << g);
    chk("bit_ready", 32'(bit_ready), 32'(exp_rdy));
    chk("evt_valid", 32'(evt_valid), 32'(ev_v));
    if (ev_v) chk("evt_lane", 32'(evt_lane), 32'(ev_l));
    chk("cnt_val", 32'(cnt_val), 32'(cnt_m[sel]));
    if (cl) begin
      model_reset();
    end else begin
      hit = 0;
      if (g >= 0) begin
        hist_m[g] = ((hist_m[g] << 1) | int'(d[g])) & 15;
        fill_m[g] = (fill_m[g] < 4) ? fill_m[g] + 1 : 4;
        hit = (fill_m[g] == 4) && (hist_m[g] == 'b1011);
        ptr_m = (g + 1) % 4;
      end
      if (hit) begin
        cnt_m[g] = (cnt_m[g] < 255) ? cnt_m[g] + 1 : 255;
        ev_v = 1;
        ev_l = g;
      end else if (ev_v && er) begin
        ev_v = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lane_bits(input int l, input logic [31:0] bits, input int n, input logic er);
    for (int i = n - 1; i >= 0; i--) cyc(4'(1 << l), 4'(int'(bits[i]) << l), er, 1'b0, l);
  endtask

  task automatic peek_cnt(input string tag, input int sel, input int exp);
    cnt_sel = sel[1:0];
    #1;
    chk(tag, 32'(cnt_val), 32'(exp));
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_bit_ready", 32'(bit_ready), 0);
    chk("rst_evt_valid", 32'(evt_valid), 0);
    chk("rst_evt_lane", 32'(evt_lane), 0);
    chk("rst_cnt_val", 32'(cnt_val), 0);
    rst = 1'b1;
    @(negedge clk);

    lane_bits(0, 'b1011, 4, 1'b1);
    chk("t1_evt_valid", 32'(evt_valid), 1);
    chk("t1_evt_lane", 32'(evt_lane), 0);
    peek_cnt("t1_cnt", 0, 1);
    cyc(4'b0, 4'b0, 1'b1, 1'b0, 0);
    chk("t1_one_cycle", 32'(evt_valid), 0);

    lane_bits(2, 'b1011011, 7, 1'b1);
    peek_cnt("t2_cnt2", 2, 2);
    peek_cnt("t2_cnt1", 1, 0);
    peek_cnt("t2_cnt3", 3, 0);

    cyc(4'b0, 4'b0, 1'b1, 1'b1, 0);
    for (int k = 0; k < 8; k++) begin
      bit_valid = 4'hf;
      bit_data = 4'h0;
      clear = 1'b0;
      #1;
      chk("t3_rr", 32'(bit_ready), 32'(1 << (k % 4)));
      cyc(4'hf, 4'h0, 1'b1, 1'b0, k % 4);
    end

    lane_bits(1, 'b1011, 4, 1'b0);
    for (int k = 0; k < 5; k++) begin
      bit_valid = 4'hf;
      evt_ready = 1'b0;
      #1;
      chk("t4_stall_rdy", 32'(bit_ready), 0);
      chk("t4_hold_lane", 32'(evt_lane), 1);
      cyc(4'hf, 4'h0, 1'b0, 1'b0, 1);
    end
    bit_valid = 4'hf;
    evt_ready = 1'b1;
    #1;
    chk("t4_resume", 32'(bit_ready != 4'b0), 1);
    cyc(4'hf, 4'h0, 1'b1, 1'b0, 1);

    lane_bits(3, 'b1, 1, 1'b1);
    for (int k = 0; k < 300; k++) lane_bits(3, 'b011, 3, 1'b1);
    peek_cnt("t5_sat", 3, 255);

    lane_bits(2, 'b1011, 4, 1'b1);
    lane_bits(2, 'b101, 3, 1'b0);
    lane_bits(1, 'b1011, 4, 1'b0);
    chk("t6_pending", 32'(evt_valid), 1);
    cyc(4'b0100, 4'b0100, 1'b1, 1'b1, 0);
    chk("t6_dropped", 32'(evt_valid), 0);
    for (int l = 0; l < 4; l++) peek_cnt("t6_cnt", l, 0);
    lane_bits(2, 'b1, 1, 1'b1);
    chk("t6_no_match", 32'(evt_valid), 0);
    lane_bits(2, 'b1011, 4, 1'b1);
    chk("t6_full_match", 32'(evt_valid), 1);

    lane_bits(1, 'b1011, 4, 1'b1);
    cyc(4'b0, 4'b0, 1'b1, 1'b0, 0);
    lane_bits(0, 'b101, 3, 1'b1);
    bit_valid = 4'b0;
    cnt_sel = 2'd1;
    #3;
    rst = 1'b0;
    #1;
    chk("t7_bit_ready", 32'(bit_ready), 0);
    chk("t7_evt_valid", 32'(evt_valid), 0);
    chk("t7_cnt", 32'(cnt_val), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    lane_bits(0, 'b1, 1, 1'b1);
    chk("t7_no_partial", 32'(evt_valid), 0);
    lane_bits(0, 'b011, 3, 1'b1);
    chk("t7_fresh_match", 32'(evt_valid), 1);

    for (int k = 0; k < 1500; k++)
      cyc(4'($urandom), 4'($urandom), 1'($urandom_range(3) != 0), 1'($urandom_range(99) == 0), $urandom_range(3));
    for (int l = 0; l < 4; l++) peek_cnt("rand_cnt", l, cnt_m[l]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
